// File: rtl/decode_stream_scoreboard_pkg.sv
// decsb_pkg: shared record type, field_mask bit positions and the masked
// record compare used by the decode stream scoreboard.
package decsb_pkg;

  localparam int DEF_CTRL_W = 64;

  localparam int FM_RD   = 0;
  localparam int FM_RS1  = 1;
  localparam int FM_RS2  = 2;
  localparam int FM_IMM  = 3;
  localparam int FM_CTRL = 4;
  localparam int FM_PC   = 5;

  typedef struct packed {
    logic [31:0]           pc;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [31:0]           imm;
    logic [DEF_CTRL_W-1:0] ctrl;
  } decsb_rec_t;

  // A pair matches when every field enabled in mask is equal; mask 0 always matches.
  function automatic logic rec_match(decsb_rec_t a, decsb_rec_t b, logic [5:0] mask);
    logic m;
    m = 1'b1;
    if (mask[FM_RD]   && (a.rd   != b.rd))   m = 1'b0;
    if (mask[FM_RS1]  && (a.rs1  != b.rs1))  m = 1'b0;
    if (mask[FM_RS2]  && (a.rs2  != b.rs2))  m = 1'b0;
    if (mask[FM_IMM]  && (a.imm  != b.imm))  m = 1'b0;
    if (mask[FM_CTRL] && (a.ctrl != b.ctrl)) m = 1'b0;
    if (mask[FM_PC]   && (a.pc   != b.pc))   m = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/decode_stream_scoreboard_if.sv
// decode_stream_scoreboard_if: both record streams, run-time controls and all
// scoreboard results. master drives the streams, slave is the scoreboard.
interface decode_stream_scoreboard_if #(
  parameter int CTRL_W    = 64,
  parameter int CNT_W     = 32,
  parameter int LOG_DEPTH = 16
);
  localparam int LOG_AW = $clog2(LOG_DEPTH);

  logic              clear;
  logic              dut_valid;
  logic [31:0]       dut_pc;
  logic [4:0]        dut_rd;
  logic [4:0]        dut_rs1;
  logic [4:0]        dut_rs2;
  logic [31:0]       dut_imm;
  logic [CTRL_W-1:0] dut_ctrl;
  logic              gold_valid;
  logic [31:0]       gold_pc;
  logic [4:0]        gold_rd;
  logic [4:0]        gold_rs1;
  logic [4:0]        gold_rs2;
  logic [31:0]       gold_imm;
  logic [CTRL_W-1:0] gold_ctrl;
  logic [5:0]        field_mask;
  logic [LOG_AW-1:0] log_rd_idx;

  logic              cmp_valid;
  logic              cmp_match;
  logic [31:0]       cmp_pc;
  logic [CNT_W-1:0]  total_cnt;
  logic [CNT_W-1:0]  match_cnt;
  logic [CNT_W-1:0]  mismatch_cnt;
  logic              dut_full;
  logic              gold_full;
  logic              overflow_err;
  logic              timeout_err;
  logic [LOG_AW:0]   log_count;
  logic [31:0]       log_rd_pc;

  modport master (
    output clear, dut_valid, dut_pc, dut_rd, dut_rs1, dut_rs2, dut_imm, dut_ctrl,
           gold_valid, gold_pc, gold_rd, gold_rs1, gold_rs2, gold_imm, gold_ctrl,
           field_mask, log_rd_idx,
    input  cmp_valid, cmp_match, cmp_pc, total_cnt, match_cnt, mismatch_cnt,
           dut_full, gold_full, overflow_err, timeout_err, log_count, log_rd_pc
  );

  modport slave (
    input  clear, dut_valid, dut_pc, dut_rd, dut_rs1, dut_rs2, dut_imm, dut_ctrl,
           gold_valid, gold_pc, gold_rd, gold_rs1, gold_rs2, gold_imm, gold_ctrl,
           field_mask, log_rd_idx,
    output cmp_valid, cmp_match, cmp_pc, total_cnt, match_cnt, mismatch_cnt,
           dut_full, gold_full, overflow_err, timeout_err, log_count, log_rd_pc
  );
endinterface

// File: rtl/decode_stream_scoreboard_fifo.sv
// decsb_fifo: synchronous FIFO with registered head storage. A push into a
// full FIFO is accepted only when a pop frees a slot in the same cycle.
module decsb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign head_o  = mem_q[rd_ptr_q];

  // Occupancy follows accepted pushes and pops; simultaneous ones cancel.
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointers and occupancy; reset or clear empties the FIFO at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: slots are only read once counted as occupied.
  always_ff @(posedge clk) begin
    if (push_ok && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/decode_stream_scoreboard.sv
// decode_stream_scoreboard: buffers DUT and golden decode records in two
// FIFOs, compares heads in order under field_mask, keeps saturating stats,
// a mismatch-PC log and sticky overflow/timeout flags.
// Optional: define DECSB_TRACE_EN for per-compare $display and print_summary.
module decode_stream_scoreboard
  import decsb_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int CTRL_W    = DEF_CTRL_W,
  parameter int CNT_W     = 32,
  parameter int LOG_DEPTH = 16,
  parameter int TIMEOUT   = 1024
) (
  input logic clk,
  input logic rst,
  decode_stream_scoreboard_if.slave bus
);
  localparam int LOG_AW = $clog2(LOG_DEPTH);
  localparam int LCW    = LOG_AW + 1;
  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam int REC_W  = $bits(decsb_rec_t);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [LCW-1:0]   LOG_MAX = LCW'(LOG_DEPTH);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT);

  decsb_rec_t dut_rec, gold_rec, dut_head, gold_head;
  logic dut_empty, gold_empty, dut_full, gold_full;
  logic pop, match_d, overflow_d, log_we;

  logic             cmp_valid_q, cmp_match_q, overflow_q, timeout_q;
  logic [31:0]      cmp_pc_q;
  logic [CNT_W-1:0] total_q, match_q, mismatch_q;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [LCW-1:0]   log_count_q;
  logic [31:0]      log_q [LOG_DEPTH];

  assign dut_rec  = '{pc: bus.dut_pc, rd: bus.dut_rd, rs1: bus.dut_rs1, rs2: bus.dut_rs2,
                      imm: bus.dut_imm, ctrl: DEF_CTRL_W'(bus.dut_ctrl)};
  assign gold_rec = '{pc: bus.gold_pc, rd: bus.gold_rd, rs1: bus.gold_rs1, rs2: bus.gold_rs2,
                      imm: bus.gold_imm, ctrl: DEF_CTRL_W'(bus.gold_ctrl)};

  decsb_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_dut_fifo (
    .clk(clk), .rst(rst), .clear_i(bus.clear), .push_i(bus.dut_valid), .pop_i(pop),
    .data_i(dut_rec), .head_o(dut_head), .full_o(dut_full), .empty_o(dut_empty)
  );

  decsb_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_gold_fifo (
    .clk(clk), .rst(rst), .clear_i(bus.clear), .push_i(bus.gold_valid), .pop_i(pop),
    .data_i(gold_rec), .head_o(gold_head), .full_o(gold_full), .empty_o(gold_empty)
  );

  assign pop        = !dut_empty && !gold_empty;
  assign match_d    = rec_match(dut_head, gold_head, bus.field_mask);
  assign overflow_d = (bus.dut_valid && dut_full && !pop) || (bus.gold_valid && gold_full && !pop);
  assign log_we     = pop && !match_d && (log_count_q < LOG_MAX) && !bus.clear;

  // Skew timer: runs while only one stream holds data, holds at TIMEOUT.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (pop || (dut_empty && gold_empty)) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_MAX) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  // Registered compare result, saturating statistics and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_valid_q <= 1'b0;
      cmp_match_q <= 1'b0;
      cmp_pc_q    <= '0;
      total_q     <= '0;
      match_q     <= '0;
      mismatch_q  <= '0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
      to_cnt_q    <= '0;
      log_count_q <= '0;
    end else if (bus.clear) begin
      cmp_valid_q <= 1'b0;
      cmp_match_q <= 1'b0;
      cmp_pc_q    <= '0;
      total_q     <= '0;
      match_q     <= '0;
      mismatch_q  <= '0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
      to_cnt_q    <= '0;
      log_count_q <= '0;
    end else begin
      cmp_valid_q <= pop;
      if (pop) begin
        cmp_match_q <= match_d;
        cmp_pc_q    <= dut_head.pc;
        if (total_q != CNT_MAX) total_q <= total_q + 1'b1;
        if (match_d) begin
          if (match_q != CNT_MAX) match_q <= match_q + 1'b1;
        end else begin
          if (mismatch_q != CNT_MAX) mismatch_q <= mismatch_q + 1'b1;
        end
      end
      if (overflow_d) overflow_q <= 1'b1;
      to_cnt_q <= to_cnt_d;
      if (to_cnt_d == TO_MAX) timeout_q <= 1'b1;
      if (log_we) log_count_q <= log_count_q + 1'b1;
    end
  end

  // Mismatch PCs fill the log in order and stop once it is full.
  always_ff @(posedge clk) begin
    if (log_we) log_q[log_count_q[LOG_AW-1:0]] <= dut_head.pc;
  end

  assign bus.cmp_valid    = cmp_valid_q;
  assign bus.cmp_match    = cmp_match_q;
  assign bus.cmp_pc       = cmp_pc_q;
  assign bus.total_cnt    = total_q;
  assign bus.match_cnt    = match_q;
  assign bus.mismatch_cnt = mismatch_q;
  assign bus.dut_full     = dut_full;
  assign bus.gold_full    = gold_full;
  assign bus.overflow_err = overflow_q;
  assign bus.timeout_err  = timeout_q;
  assign bus.log_count    = log_count_q;
  assign bus.log_rd_pc    = ({1'b0, bus.log_rd_idx} < log_count_q) ? log_q[bus.log_rd_idx] : '0;

`ifdef DECSB_TRACE_EN
  // Simulation trace of every comparison with both records.
  always @(posedge clk) begin
    if (!rst && !bus.clear && pop) begin
      $display("%s pc=%h dut{rd=%0d rs1=%0d rs2=%0d imm=%h ctrl=%h} gold{pc=%h rd=%0d rs1=%0d rs2=%0d imm=%h ctrl=%h}",
               match_d ? "[MATCH]" : "[MISMATCH]", dut_head.pc,
               dut_head.rd, dut_head.rs1, dut_head.rs2, dut_head.imm, dut_head.ctrl,
               gold_head.pc, gold_head.rd, gold_head.rs1, gold_head.rs2, gold_head.imm, gold_head.ctrl);
    end
  end

  task automatic print_summary();
    $display("decsb total=%0d match=%0d mismatch=%0d overflow=%0b timeout=%0b logged=%0d",
             total_q, match_q, mismatch_q, overflow_q, timeout_q, log_count_q);
    for (int i = 0; i < LOG_DEPTH; i++) begin
      if (i < int'(log_count_q)) $display("decsb log[%0d] pc=%h", i, log_q[i]);
    end
  endtask
`endif
endmodule

// File: doc/decode_stream_scoreboard.md
# decode_stream_scoreboard

Parametrised successor to the lockstep decoder checker. It buffers decoded-instruction records from the DUT decoder and the golden model in two independent FIFOs, so the streams may arrive skewed by up to DEPTH records. It compares head records in order under a run-time field mask, and keeps saturating statistics, a mismatch-PC log and sticky error flags. It sits in the TOP_CORE bench between the decoder tap and the reference model.

## Interface
- DEPTH, 8 — entries per stream FIFO; power of two, ≥2
- CTRL_W, 64 — width of the control-type (Single_Instruction) field
- CNT_W, 32 — statistics counter width
- LOG_DEPTH, 16 — mismatch-PC log entries; power of two
- TIMEOUT, 1024 — maximum cycles one FIFO may hold data while the other is empty
---
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- clear  in  1  synchronous clear of all state
- dut_valid / gold_valid  in  1  push a record into the matching stream
- dut_pc / gold_pc  in  32  instruction PC
- dut_rd, dut_rs1, dut_rs2 / gold_*  in  5 each  register fields
- dut_imm / gold_imm  in  32  immediate
- dut_ctrl / gold_ctrl  in  CTRL_W  control type
- field_mask  in  6  compare enables: [0] rd, [1] rs1, [2] rs2, [3] imm, [4] ctrl, [5] pc
- log_rd_idx  in  $clog2(LOG_DEPTH)  log read index
- cmp_valid  out  1  a comparison completed
- cmp_match  out  1  result of that comparison
- cmp_pc  out  32  DUT PC of the compared pair
- total_cnt, match_cnt, mismatch_cnt  out  CNT_W  statistics
- dut_full, gold_full  out  1  FIFO full
- overflow_err  out  1  sticky: a push was dropped
- timeout_err  out  1  sticky: stream-skew timeout
- log_count  out  $clog2(LOG_DEPTH)+1  valid log entries
- log_rd_pc  out  32  log entry at log_rd_idx (combinational read)

## Operation
- Each push stores {pc, rd, rs1, rs2, imm, ctrl} in its own stream FIFO.
- When both FIFOs are non-empty, both heads pop in the same cycle and are compared.
- match = AND over every enabled field of (dut === gold). A field is masked out when its field_mask bit is 0. With field_mask = 0, every comparison matches.
- On each comparison:
  - total_cnt increments.
  - match_cnt or mismatch_cnt increments.
  - All counters saturate at 2^CNT_W−1.
- On a mismatch, the DUT PC is written to log[log_count] while log_count < LOG_DEPTH. Further mismatches are still counted but not logged; there is no wrap-around.
- Push when the FIFO is full and no pop occurs that cycle: the record is dropped and overflow_err sets. Push and pop in the same cycle on a full FIFO: the push is accepted.
- Timeout counter:
  - Increments each cycle exactly one FIFO is non-empty and the other is empty.
  - Resets to 0 on any pop, or when both FIFOs are empty.
  - Reaching TIMEOUT sets timeout_err and holds the counter.
- clear has the same effect as reset, but synchronously: FIFOs, counters, log and flags all clear. clear has priority over push and compare in the same cycle.

## Timing
- A push at edge N makes the entry visible at the head in cycle N+1. Pushes into two empty FIFOs at edge N compare during cycle N+1.
- The comparison result is registered: cmp_valid, cmp_match, cmp_pc and the counters update at the edge that pops, and are visible one cycle after the heads were presented.
- Throughput is one comparison per cycle.
- Reset values:
  - All counters 0, log_count 0, cmp_valid 0, cmp_match 0, cmp_pc 0.
  - dut_full 0, gold_full 0, overflow_err 0, timeout_err 0.
  - FIFOs empty; log_rd_pc 0 while log_count = 0.
- Reset asserted mid-stream discards all buffered records immediately, without waiting for a clock.

## Configuration
- DECSB_TRACE_EN defined: every comparison issues a simulation $display of [MATCH]/[MISMATCH], PC, and DUT and golden fields. A print_summary task prints the counters and the logged PCs.
- DECSB_TRACE_EN undefined: no display statements and no task. The block is fully synthesizable, with identical port behaviour.

## Structure
- decsb_pkg holds:
  - decsb_rec_t, the packed record struct parameterised through CTRL_W via the package localparam default.
  - The field_mask bit-index constants FM_RD … FM_PC.
- One sub-module, decsb_fifo: parametrised synchronous FIFO with push, pop, head, full and empty. It is instantiated twice.

## Test plan
- Lockstep: push 5 identical records on both streams, field_mask = 6'h3F → 5 cmp_valid pulses, all matching; total = 5, match = 5, mismatch = 0.
- Skew: push 4 DUT records, then 4 golden records 6 cycles later → 4 matches in order, no errors.
- Mismatch and mask: gold_imm differs at PC 0x100. With field_mask = 6'h3F → mismatch, log[0] = 0x100. Repeat with field_mask[3] = 0 → match.
- Log saturation: 20 mismatches with LOG_DEPTH = 16 → mismatch_cnt = 20, log_count = 16, log[15] = PC of the 16th mismatch.
- Overflow and timeout: push 9 DUT records, no golden, DEPTH = 8 → dut_full = 1, overflow_err = 1. After TIMEOUT cycles → timeout_err = 1.
- Reset and clear: assert rst with 3 records buffered → all outputs 0 and FIFOs empty. clear asserted in the same cycle as a compare → counters stay 0.
